// File: rtl/isp_word_packer.sv
// -----------------------------------------------------------------------------
// isp_word_packer
//   Repacks 24-bit BGR pixels coming out of the ISP into 32-bit little-endian
//   words for the frame-buffer writer. Four pixels become three words. The
//   last word of a line is filled with PAD_BYTE. Line/frame sync flags are
//   checked against a line length that is latched on every frame start.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both high. Upstream pixels use in_valid/out_ready. Downstream words use
//   out_valid/in_ready. out_valid, out_data and out_user come straight from
//   flops and do not change while a word is stalled.
//
// Ports
//   clk          pixel/ISP clock
//   reset        asynchronous, active-low reset
//   in_valid     upstream pixel valid
//   out_ready    ready to upstream (combinational)
//   in_data      pixel; [7:0] is packed first, then [15:8], then [23:16]
//   in_user      [0] hstart, [1] fstart
//   out_valid    packed word valid
//   in_ready     downstream ready
//   out_data     packed word; [7:0] is the earliest byte
//   out_user     [0] first word of line, [1] first word of frame,
//                [2] last word of line
//   line_pixels  pixels per line, latched on each accepted fstart pixel
//   sync_err     one-cycle pulse when hstart/fstart arrives mid-line
//   dbg_state    current FSM state (0 idle, 1 run, 2 drain)
// -----------------------------------------------------------------------------
module isp_word_packer #(
    parameter int         COLOR_DEPTH = 8,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        out_ready,
    input  logic [23:0] in_data,
    input  logic [7:0]  in_user,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_user,
    input  logic [15:0] line_pixels,
    output logic        sync_err,
    output logic [1:0]  dbg_state
);

    // Only 8-bit channels are supported, so every pixel is three bytes.
    localparam int PIX_BYTES = (3 * COLOR_DEPTH) / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] buf_q, buf_d;         // byte i lives at [8i+7:8i]; bytes >= cnt are zero
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_len_q, line_len_d;
    logic        hs_mark_q, hs_mark_d;
    logic        fs_mark_q, fs_mark_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [7:0]  out_user_q, out_user_d;
    logic        sync_err_q, sync_err_d;

    logic        accept;
    logic        consume;
    logic [47:0] buf_work;
    logic [2:0]  cnt_work;
    logic [15:0] pix_next;
    logic [15:0] len_eff;
    logic        unused_user;

    assign accept      = in_valid && out_ready;
    assign consume     = out_valid_q && in_ready;
    assign unused_user = ^in_user[7:2];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            pix_cnt_q   <= '0;
            line_len_q  <= '0;
            hs_mark_q   <= 1'b0;
            fs_mark_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            line_len_q  <= line_len_d;
            hs_mark_q   <= hs_mark_d;
            fs_mark_q   <= fs_mark_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_len_d = line_len_q;
        hs_mark_d  = hs_mark_q;
        fs_mark_d  = fs_mark_q;
        sync_err_d = 1'b0;
        buf_work   = buf_q;
        cnt_work   = cnt_q;
        pix_next   = pix_cnt_q;
        len_eff    = line_len_q;

        // A word leaving this cycle frees its four bytes before new ones append.
        if (consume) begin
            buf_work  = buf_q >> 32;
            cnt_work  = (cnt_q > 3'd4) ? cnt_q - 3'd4 : 3'd0;
            hs_mark_d = 1'b0;
            fs_mark_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && in_user[1] && (line_pixels != 16'd0)) begin
                    buf_d      = {24'd0, in_data};
                    cnt_d      = 3'(PIX_BYTES);
                    line_len_d = line_pixels;
                    pix_cnt_d  = 16'd1;
                    hs_mark_d  = 1'b1;
                    fs_mark_d  = 1'b1;
                    state_d    = (line_pixels == 16'd1) ? S_DRAIN : S_RUN;
                end
            end

            S_RUN: begin
                buf_d = buf_work;
                cnt_d = cnt_work;
                if (accept) begin
                    // A frame start re-latches the length. A zero length keeps the old one.
                    if (in_user[1] && (line_pixels != 16'd0)) begin
                        len_eff = line_pixels;
                    end
                    line_len_d = len_eff;
                    if ((in_user[0] || in_user[1]) && (pix_cnt_q != 16'd0)) begin
                        // Mid-line sync: drop the partial line and restart with this pixel.
                        sync_err_d = 1'b1;
                        buf_d      = {24'd0, in_data};
                        cnt_d      = 3'(PIX_BYTES);
                        pix_next   = 16'd1;
                        hs_mark_d  = 1'b1;
                        fs_mark_d  = in_user[1];
                    end else begin
                        buf_d    = buf_work | ({24'd0, in_data} << {cnt_work, 3'b000});
                        cnt_d    = cnt_work + 3'(PIX_BYTES);
                        pix_next = pix_cnt_q + 16'd1;
                        if (in_user[0] || in_user[1]) begin
                            hs_mark_d = 1'b1;
                        end
                        if (in_user[1]) begin
                            fs_mark_d = 1'b1;
                        end
                    end
                    pix_cnt_d = pix_next;
                    if (pix_next == len_eff) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (consume) begin
                    if (cnt_q <= 3'd4) begin
                        buf_d     = '0;
                        cnt_d     = 3'd0;
                        pix_cnt_d = 16'd0;
                        state_d   = S_RUN;
                    end else begin
                        buf_d = buf_work;
                        cnt_d = cnt_work;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // The word registers are loaded from the next buffer contents. A pixel
    // accepted at edge t can therefore show up in a word right after edge t.
    always_comb begin
        case (state_q)
            S_IDLE:  out_ready = 1'b1;
            S_RUN:   out_ready = (cnt_q <= 3'd3) || in_ready;
            default: out_ready = 1'b0;
        endcase

        out_valid_d = ((state_d == S_RUN) && (cnt_d >= 3'd4)) ||
                      ((state_d == S_DRAIN) && (cnt_d != 3'd0));

        out_data_d = '0;
        for (int i = 0; i < 4; i++) begin
            out_data_d[8*i +: 8] = (cnt_d > 3'(i)) ? buf_d[8*i +: 8] : PAD_BYTE;
        end

        out_user_d = '0;
        if (out_valid_d) begin
            out_user_d = {5'd0, (state_d == S_DRAIN) && (cnt_d <= 3'd4), fs_mark_d, hs_mark_d};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_user  = out_user_q;
    assign sync_err  = sync_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_isp_word_packer.sv
module tb_isp_word_packer;

    // ------------------------------------------------------------ clock / reset
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] in_data;
    logic [7:0]  in_user;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_user;
    logic [15:0] line_pixels;
    logic        sync_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    isp_word_packer #(.COLOR_DEPTH(8), .PAD_BYTE(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_data    (in_data),
        .in_user    (in_user),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_user   (out_user),
        .line_pixels(line_pixels),
        .sync_err   (sync_err),
        .dbg_state  (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int sync_cnt = 0;

    // Expected words: {out_user, out_data}
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge clk) begin
        if (sync_err) sync_cnt++;
        if (reset && out_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", out_data, 32'hDEAD_BEEF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("word_data", out_data, e[31:0]);
                check("word_user", {24'd0, out_user}, {24'd0, e[39:32]});
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic send_pix(input logic [23:0] d, input logic [7:0] u);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_user  = u;
        @(negedge clk);
        while (!out_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!out_ready) check("accept_timeout", {31'd0, out_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_user  = 8'h00;
    endtask

    task automatic wait_drain(input string tag);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check(tag, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] u, input logic [31:0] d);
        exp_q.push_back({u, d});
    endtask

    // Sends one full line of pixels; the first carries fstart.
    task automatic send_line4(input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
        send_pix(p0, 8'h02);
        send_pix(p1, 8'h00);
        send_pix(p2, 8'h00);
        send_pix(p3, 8'h00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ tests
    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_user     = '0;
        in_ready    = 1'b1;
        line_pixels = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_user", {24'd0, out_user}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("rst_out_ready", {31'd0, out_ready}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic 4-pixel line
        sync_cnt = 0;
        line_pixels = 16'd4;
        push_word(8'h03, 32'h0403_0201);
        push_word(8'h00, 32'h0807_0605);
        push_word(8'h04, 32'h0C0B_0A09);
        send_line4(24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A);
        wait_drain("t1_drain");
        check("t1_sync_cnt", sync_cnt, 0);
        check("t1_state_run", {30'd0, dbg_state}, 32'd1);

        // 2: 5-pixel line, last word padded
        line_pixels = 16'd5;
        push_word(8'h03, 32'h0403_0201);
        push_word(8'h00, 32'h0807_0605);
        push_word(8'h00, 32'h0C0B_0A09);
        push_word(8'h04, 32'h000F_0E0D);
        send_pix(24'h030201, 8'h02);
        send_pix(24'h060504, 8'h00);
        send_pix(24'h090807, 8'h00);
        send_pix(24'h0C0B0A, 8'h00);
        send_pix(24'h0F0E0D, 8'h00);
        wait_drain("t2_drain");
        check("t2_sync_cnt", sync_cnt, 0);

        // 3: downstream stall for 10 cycles after the first word is valid
        line_pixels = 16'd4;
        in_ready    = 1'b0;
        push_word(8'h03, 32'h0403_0201);
        push_word(8'h00, 32'h0807_0605);
        push_word(8'h04, 32'h0C0B_0A09);
        fork
            send_line4(24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A);
            begin
                int waited;
                waited = 0;
                while (!out_valid && waited < 50) begin
                    @(negedge clk);
                    waited++;
                end
                check("t3_first_valid", {31'd0, out_valid}, 32'd1);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("t3_hold_data", out_data, 32'h0403_0201);
                    check("t3_hold_ready", {31'd0, out_ready}, 32'd0);
                end
                check("t3_hold_user", {24'd0, out_user}, 32'h03);
                @(posedge clk);
                #1;
                in_ready = 1'b1;
            end
        join
        wait_drain("t3_drain");

        // 4: hstart on the 3rd pixel of a 4-pixel line
        sync_cnt = 0;
        push_word(8'h03, 32'h2423_2221);
        push_word(8'h01, 32'h2A29_2827);
        push_word(8'h00, 32'h2E2D_2C2B);
        push_word(8'h04, 32'h3231_302F);
        send_pix(24'h232221, 8'h02);
        send_pix(24'h262524, 8'h00);
        send_pix(24'h292827, 8'h01);
        send_pix(24'h2C2B2A, 8'h00);
        send_pix(24'h2F2E2D, 8'h00);
        send_pix(24'h323130, 8'h00);
        wait_drain("t4_drain");
        check("t4_sync_pulse_cycles", sync_cnt, 1);

        // 5: pixels before any fstart are swallowed in idle
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 24'(k * 24'h010101 + 24'h101010);
            in_user  = 8'h00;
            @(negedge clk);
            check("t5_ready", {31'd0, out_ready}, 32'd1);
            check("t5_no_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t5_state_idle", {30'd0, dbg_state}, 32'd0);

        // 6: reset mid-line with five bytes buffered
        line_pixels = 16'd8;
        push_word(8'h03, 32'h6463_6261);
        send_pix(24'h636261, 8'h02);
        send_pix(24'h666564, 8'h00);
        send_pix(24'h696867, 8'h00);
        #1;
        reset = 1'b0;
        #1;
        check("t6_valid_async", {31'd0, out_valid}, 32'd0);
        check("t6_data_async", out_data, 32'd0);
        check("t6_state_async", {30'd0, dbg_state}, 32'd0);
        check("t6_leftover", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_pix(24'h515151, 8'h00);
        send_pix(24'h525252, 8'h01);
        send_pix(24'h535353, 8'h00);
        @(negedge clk);
        check("t6_no_valid_before_fstart", {31'd0, out_valid}, 32'd0);
        line_pixels = 16'd4;
        push_word(8'h03, 32'h4443_4241);
        push_word(8'h00, 32'h4847_4645);
        push_word(8'h04, 32'h4C4B_4A49);
        @(posedge clk);
        #1;
        send_line4(24'h434241, 24'h464544, 24'h494847, 24'h4C4B4A);
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
